uart_cmd_decoder: RTL and testbench

Sits directly downstream of the UART receiver. Assembles received bytes into fixed 5-byte command frames, validates each frame with an XOR checksum, and issues a one-cycle register-write strobe (address + 16-bit data) to the threshold/config register bank. Malformed or stalled frames are dropped and flagged with an error pulse.

---
 rtl/uart_cmd_decoder_if.sv | 31 +++
 rtl/uart_cmd_decoder.sv | 130 +++++++++++++
 tb/tb_uart_cmd_decoder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_decoder_if.sv
// Byte stream from the UART receiver into the decoder, and the register-write
// port the decoder drives toward the threshold/config bank.
interface uart_cmd_decoder_if;
  logic        i_Rx_DV_n;
  logic [7:0]  i_Rx_Byte;
  logic        o_Wr_En;
  logic [7:0]  o_Wr_Addr;
  logic [15:0] o_Wr_Data;
  logic        o_Frame_Err;
  logic        o_Busy;

  modport slave (
    input  i_Rx_DV_n,
    input  i_Rx_Byte,
    output o_Wr_En,
    output o_Wr_Addr,
    output o_Wr_Data,
    output o_Frame_Err,
    output o_Busy
  );

  modport master (
    output i_Rx_DV_n,
    output i_Rx_Byte,
    input  o_Wr_En,
    input  o_Wr_Addr,
    input  o_Wr_Data,
    input  o_Frame_Err,
    input  o_Busy
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Assembles 5-byte UART command frames (sync, addr, data_h, data_l, xor chk)
// into one-cycle register-write strobes; bad or stalled frames pulse an error.
module uart_cmd_decoder #(
  parameter logic [7:0] SYNC_BYTE    = 8'hAA,
  parameter int         TIMEOUT_CLKS = 43400
) (
  input logic                 i_Clock,
  input logic                 i_Reset_n,
  uart_cmd_decoder_if.slave   bus
);

  localparam int CW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA_H,
    DATA_L,
    CHECK
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          r_dv_prev;
  logic          accept;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [CW-1:0] cnt_inc;
  logic [7:0]    addr_sh;
  logic [7:0]    addr_sh_next;
  logic [15:0]   data_sh;
  logic [15:0]   data_sh_next;
  logic          wr_en_next;
  logic          err_next;
  logic          load_out;

  // A held-low valid counts once: only the falling edge accepts a byte.
  assign accept  = !bus.i_Rx_DV_n && r_dv_prev;
  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    state_next   = state;
    cnt_next     = cnt_inc;
    addr_sh_next = addr_sh;
    data_sh_next = data_sh;
    wr_en_next   = 1'b0;
    err_next     = 1'b0;
    load_out     = 1'b0;

    if (state == IDLE || accept) begin
      cnt_next = '0;
    end

    case (state)
      IDLE: begin
        if (accept && bus.i_Rx_Byte == SYNC_BYTE) begin
          state_next = ADDR;
        end
      end
      ADDR: begin
        if (accept) begin
          addr_sh_next = bus.i_Rx_Byte;
          state_next   = DATA_H;
        end
      end
      DATA_H: begin
        if (accept) begin
          data_sh_next[15:8] = bus.i_Rx_Byte;
          state_next         = DATA_L;
        end
      end
      DATA_L: begin
        if (accept) begin
          data_sh_next[7:0] = bus.i_Rx_Byte;
          state_next        = CHECK;
        end
      end
      CHECK: begin
        if (accept) begin
          if (bus.i_Rx_Byte == (addr_sh ^ data_sh[15:8] ^ data_sh[7:0])) begin
            wr_en_next = 1'b1;
            load_out   = 1'b1;
          end else begin
            err_next = 1'b1;
          end
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // The limit is judged on the value the counter is about to take, so the
    // registered error lands exactly TIMEOUT_CLKS cycles after the last byte.
    if (state != IDLE && !accept && cnt_inc == LIMIT) begin
      err_next   = 1'b1;
      state_next = IDLE;
      cnt_next   = '0;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state           <= IDLE;
      r_dv_prev       <= 1'b1;
      cnt             <= '0;
      addr_sh         <= '0;
      data_sh         <= '0;
      bus.o_Wr_En     <= 1'b0;
      bus.o_Wr_Addr   <= '0;
      bus.o_Wr_Data   <= '0;
      bus.o_Frame_Err <= 1'b0;
      bus.o_Busy      <= 1'b0;
    end else begin
      state           <= state_next;
      r_dv_prev       <= bus.i_Rx_DV_n;
      cnt             <= cnt_next;
      addr_sh         <= addr_sh_next;
      data_sh         <= data_sh_next;
      bus.o_Wr_En     <= wr_en_next;
      bus.o_Frame_Err <= err_next;
      bus.o_Busy      <= (state_next != IDLE);
      if (load_out) begin
        bus.o_Wr_Addr <= addr_sh;
        bus.o_Wr_Data <= data_sh;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: frames are driven byte by byte and every
// expected write/error pulse is queued with its cycle and checked when it fires.
module tb_uart_cmd_decoder;

  localparam logic [7:0] SYNC    = 8'hAA;
  localparam int         TIMEOUT = 50;

  typedef struct {
    int          cyc;
    bit          is_err;
    logic [7:0]  addr;
    logic [15:0] data;
  } exp_t;

  logic        clk;
  logic        reset_n;
  int          cyc;
  int          last_accept;
  int          total;
  int          bad;
  logic [7:0]  model_addr;
  logic [15:0] model_data;
  exp_t        exp_q[$];

  uart_cmd_decoder_if bus ();

  uart_cmd_decoder #(
    .SYNC_BYTE    (SYNC),
    .TIMEOUT_CLKS (TIMEOUT)
  ) dut (
    .i_Clock   (clk),
    .i_Reset_n (reset_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One byte on the receiver handshake; optionally queues the pulse it causes.
  task automatic apply_stimulus(input logic [7:0] b, input int low, input bit push, input exp_t e_in);
    exp_t e;
    e = e_in;
    @(posedge clk);
    #1;
    bus.i_Rx_Byte = b;
    bus.i_Rx_DV_n = 1'b0;
    last_accept   = cyc;
    if (push) begin
      e.cyc = cyc + 1;
      exp_q.push_back(e);
    end
    repeat (low) @(posedge clk);
    #1;
    bus.i_Rx_DV_n = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] dh, input logic [7:0] dl,
                            input logic [7:0] chk, input int low);
    exp_t none;
    exp_t e;
    none = '{cyc: 0, is_err: 1'b0, addr: 8'h00, data: 16'h0000};
    if (chk == (a ^ dh ^ dl)) begin
      model_addr = a;
      model_data = {dh, dl};
      e = '{cyc: 0, is_err: 1'b0, addr: a, data: {dh, dl}};
    end else begin
      e = '{cyc: 0, is_err: 1'b1, addr: model_addr, data: model_data};
    end
    apply_stimulus(SYNC, low, 1'b0, none);
    check_output("busy_after_sync", {31'd0, bus.o_Busy}, 32'd1);
    apply_stimulus(a, low, 1'b0, none);
    apply_stimulus(dh, low, 1'b0, none);
    apply_stimulus(dl, low, 1'b0, none);
    apply_stimulus(chk, low, 1'b1, e);
  endtask

  // Bounded wait, then every queued pulse must have been seen.
  task automatic drain(input int cycles);
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    check_output("queue_drained", exp_q.size(), 32'd0);
    check_output("busy_idle", {31'd0, bus.o_Busy}, 32'd0);
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n === 1'b1 && (bus.o_Wr_En === 1'b1 || bus.o_Frame_Err === 1'b1)) begin
      check_output("pulse_exclusive", {31'd0, bus.o_Wr_En & bus.o_Frame_Err}, 32'd0);
      check_output("pulse_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("pulse_cycle", cyc, e.cyc);
        check_output("pulse_is_err", {31'd0, bus.o_Frame_Err}, {31'd0, e.is_err});
        check_output("wr_addr", {24'd0, bus.o_Wr_Addr}, {24'd0, e.addr});
        check_output("wr_data", {16'd0, bus.o_Wr_Data}, {16'd0, e.data});
        check_output("busy_drop", {31'd0, bus.o_Busy}, 32'd0);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    exp_t none;
    exp_t e;
    none          = '{cyc: 0, is_err: 1'b0, addr: 8'h00, data: 16'h0000};
    total         = 0;
    bad           = 0;
    model_addr    = 8'h00;
    model_data    = 16'h0000;
    reset_n       = 1'b0;
    bus.i_Rx_DV_n = 1'b1;
    bus.i_Rx_Byte = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_wr_en", {31'd0, bus.o_Wr_En}, 32'd0);
    check_output("rst_wr_addr", {24'd0, bus.o_Wr_Addr}, 32'd0);
    check_output("rst_wr_data", {16'd0, bus.o_Wr_Data}, 32'd0);
    check_output("rst_frame_err", {31'd0, bus.o_Frame_Err}, 32'd0);
    check_output("rst_busy", {31'd0, bus.o_Busy}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    $display("[TB] valid frame");
    send_frame(8'h05, 8'h12, 8'h34, 8'h23, 2);
    drain(4);

    $display("[TB] bad checksum");
    send_frame(8'h05, 8'h12, 8'h34, 8'h24, 2);
    drain(4);

    $display("[TB] garbage before sync");
    apply_stimulus(8'h55, 2, 1'b0, none);
    check_output("garbage_busy_55", {31'd0, bus.o_Busy}, 32'd0);
    apply_stimulus(8'h00, 2, 1'b0, none);
    check_output("garbage_busy_00", {31'd0, bus.o_Busy}, 32'd0);
    apply_stimulus(8'hFF, 2, 1'b0, none);
    check_output("garbage_busy_ff", {31'd0, bus.o_Busy}, 32'd0);
    send_frame(8'h7F, 8'h00, 8'h01, 8'h7E, 2);
    drain(4);

    $display("[TB] timeout");
    apply_stimulus(SYNC, 2, 1'b0, none);
    apply_stimulus(8'h05, 2, 1'b0, none);
    e = '{cyc: last_accept + TIMEOUT, is_err: 1'b1, addr: model_addr, data: model_data};
    exp_q.push_back(e);
    drain(TIMEOUT + 5);
    send_frame(8'h21, 8'hBE, 8'hEF, 8'h21 ^ 8'hBE ^ 8'hEF, 2);
    drain(4);

    $display("[TB] long valid pulse");
    send_frame(8'h05, 8'h12, 8'h34, 8'h23, 5);
    drain(4);

    $display("[TB] back-to-back frames");
    send_frame(8'h10, 8'h00, 8'h01, 8'h11, 1);
    send_frame(8'h11, 8'hAA, 8'h55, 8'h11 ^ 8'hAA ^ 8'h55, 1);
    drain(4);

    $display("[TB] reset mid-frame");
    apply_stimulus(SYNC, 2, 1'b0, none);
    apply_stimulus(8'h05, 2, 1'b0, none);
    apply_stimulus(8'h12, 2, 1'b0, none);
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_addr = 8'h00;
    model_data = 16'h0000;
    check_output("midrst_busy", {31'd0, bus.o_Busy}, 32'd0);
    check_output("midrst_wr_addr", {24'd0, bus.o_Wr_Addr}, 32'd0);
    check_output("midrst_wr_data", {16'd0, bus.o_Wr_Data}, 32'd0);
    apply_stimulus(8'h34, 2, 1'b0, none);
    apply_stimulus(8'h23, 2, 1'b0, none);
    drain(TIMEOUT + 5);
    send_frame(8'h01, 8'h00, 8'h02, 8'h03, 2);
    drain(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
